// File: rtl/nios_system_key_pio_in.sv
// Avalon-MM input PIO for push-buttons/switches: 2-flop synchronizer, per-bit debouncer,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module nios_system_key_pio_in #(
   parameter int              WIDTH           = 4,
   parameter int              DEBOUNCE_CYCLES = 50000,
   parameter int              EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] w_db;
   logic [WIDTH-1:0] r_db_d;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge_capture;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_ev;
   logic [WIDTH-1:0] w_clr;
   logic [31:0]      w_rd_mux;
   logic [31:0]      r_readdata;
   logic             r_irq;
   logic             w_wr_en;
   logic             w_rd_en;
   logic             w_unused;

   assign w_wr_en  = chipselect & ~write_n;
   assign w_rd_en  = chipselect & ~read_n;
   // Upper writedata bits are deliberately ignored.
   assign w_unused = &{1'b0, writedata};

   // Two-flop synchronizer on the asynchronous pins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= RESET_LEVEL;
         r_sync2 <= RESET_LEVEL;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES > 0) begin : g_debounce
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CW-1:0] r_cnt;
            logic          r_db_bit;

            // A new level is accepted only after it has been stable for the full window
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  r_cnt    <= '0;
                  r_db_bit <= RESET_LEVEL[i];
               end else if (r_sync2[i] == r_db_bit) begin
                  r_cnt    <= '0;
                  r_db_bit <= r_db_bit;
               end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                  r_cnt    <= '0;
                  r_db_bit <= r_sync2[i];
               end else if (r_cnt != {CW{1'b1}}) begin
                  r_cnt    <= r_cnt + CW'(1);
                  r_db_bit <= r_db_bit;
               end else begin
                  r_cnt    <= r_cnt;
                  r_db_bit <= r_db_bit;
               end
            end

            assign w_db[i] = r_db_bit;
         end
      end else begin : g_bypass
         logic [WIDTH-1:0] r_db;

         // Debounce bypassed: follow the synchronized pins directly
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_db <= RESET_LEVEL;
            end else begin
               r_db <= r_sync2;
            end
         end

         assign w_db = r_db;
      end
   endgenerate

   assign w_rise = w_db & ~r_db_d;
   assign w_fall = ~w_db & r_db_d;

   // Event selection by configured edge type
   always_comb begin
      case (EDGE_TYPE)
         32'sd0:  w_ev = w_rise;
         32'sd1:  w_ev = w_fall;
         default: w_ev = w_rise | w_fall;
      endcase
   end

   // Write-1-to-clear vector for the edge capture register
   always_comb begin
      if (w_wr_en && (address == 2'd3)) begin
         w_clr = writedata[WIDTH-1:0];
      end else begin
         w_clr = '0;
      end
   end

   // Read data selection; unused upper bits read as zero
   always_comb begin
      case (address)
         2'd0:    w_rd_mux = 32'(w_db);
         2'd1:    w_rd_mux = 32'(r_irq_mask);
         2'd3:    w_rd_mux = 32'(r_edge_capture);
         default: w_rd_mux = 32'd0;
      endcase
   end

   // Control/status registers; a new event beats a simultaneous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_db_d         <= RESET_LEVEL;
         r_irq_mask     <= '0;
         r_edge_capture <= '0;
         r_irq          <= 1'b0;
      end else begin
         r_db_d         <= w_db;
         r_edge_capture <= (r_edge_capture & ~w_clr) | w_ev;
         r_irq          <= |(r_edge_capture & r_irq_mask);
         if (w_wr_en && (address == 2'd1)) begin
            r_irq_mask <= writedata[WIDTH-1:0];
         end else begin
            r_irq_mask <= r_irq_mask;
         end
      end
   end

   // Registered read port with one cycle of latency; holds when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= 32'd0;
      end else if (w_rd_en) begin
         r_readdata <= w_rd_mux;
      end else begin
         r_readdata <= r_readdata;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule

// File: tb/tb_nios_system_key_pio_in.sv
// Self-checking bench for nios_system_key_pio_in (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges).
module tb_nios_system_key_pio_in;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int          n_tests;
   int          n_fail;
   logic [31:0] sb_q[$];
   logic [31:0] exp;

   nios_system_key_pio_in #(
      .WIDTH(4),
      .DEBOUNCE_CYCLES(4),
      .EDGE_TYPE(1),
      .RESET_LEVEL(4'hF)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .address(address),
      .chipselect(chipselect),
      .read_n(read_n),
      .write_n(write_n),
      .writedata(writedata),
      .in_port(in_port),
      .readdata(readdata),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Issue a one-cycle read and queue what it must return; called at a negedge
   task automatic do_read(input logic [1:0] a, input logic [31:0] e);
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = a;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(posedge clk);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task test_reset;
      reset_n = 1'b0;
      in_port = 4'hF;
      tick(3);
      n_tests++;
      if (readdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_readdata: got %h want %h", readdata, 32'd0);
      end
      reset_n = 1'b1;
      tick(3);
      do_read(2'd0, 32'h0000000F);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL reset_data: got %h want %h", readdata, exp); end
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL reset_capture: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
   endtask

   task test_debounce_edge;
      in_port = 4'hE;
      tick(5);
      do_read(2'd0, 32'h0000000F);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL db_before_accept: got %h want %h", readdata, exp); end
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL capture_before: got %h want %h", readdata, exp); end
      do_read(2'd0, 32'h0000000E);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL db_accepted: got %h want %h", readdata, exp); end
      do_read(2'd3, 32'h1);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL capture_set: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
   endtask

   task test_mask_irq;
      do_write(2'd1, 32'h1);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %b want 0", irq); end
      tick(1);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raised: got %b want 1", irq); end
      do_write(2'd1, 32'hFFFF_FFF1);
      do_read(2'd1, 32'h1);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL mask_upper_bits: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_held: got %b want 1", irq); end
      do_write(2'd3, 32'h1);
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL w1c_clear: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b want 0", irq); end
      do_write(2'd1, 32'hF);
      do_write(2'd2, 32'hF);
      do_read(2'd2, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL reserved_read: got %h want %h", readdata, exp); end
      do_write(2'd0, 32'h0);
      do_read(2'd0, 32'hE);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL data_write_ignored: got %h want %h", readdata, exp); end
   endtask

   task test_glitch;
      in_port = 4'hC;
      tick(3);
      in_port = 4'hE;
      tick(8);
      do_read(2'd0, 32'hE);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL glitch_db: got %h want %h", readdata, exp); end
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL glitch_capture: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq: got %b want 0", irq); end
   endtask

   task test_clear_vs_set;
      in_port = 4'hA;
      tick(6);
      do_write(2'd3, 32'hF);
      do_read(2'd3, 32'h4);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL set_wins: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: got %b want 1", irq); end
      do_write(2'd3, 32'h4);
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL bit2_clear: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL bit2_irq: got %b want 0", irq); end
   endtask

   task test_reset_mid_debounce;
      in_port = 4'hF;
      tick(10);
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL rise_ignored: got %h want %h", readdata, exp); end
      in_port = 4'h7;
      tick(4);
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (readdata !== 32'd0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: readdata=%h irq=%b want 0/0", readdata, irq);
      end
      tick(2);
      reset_n = 1'b1;
      do_read(2'd0, 32'hF);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL rst_db: got %h want %h", readdata, exp); end
      do_read(2'd1, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL rst_mask: got %h want %h", readdata, exp); end
      in_port = 4'hF;
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL rst_capture: got %h want %h", readdata, exp); end
      tick(10);
      do_read(2'd3, 32'h0);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL no_edge_after_rst: got %h want %h", readdata, exp); end
      do_read(2'd0, 32'hF);
      n_tests++; exp = sb_q.pop_front();
      if (readdata !== exp) begin n_fail++; $display("FAIL db_after_rst: got %h want %h", readdata, exp); end
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_rst: got %b want 0", irq); end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = 32'd0;
      in_port    = 4'hF;
      @(negedge clk);
      test_reset;
      test_debounce_edge;
      test_mask_irq;
      test_glitch;
      test_clear_vs_set;
      test_reset_mid_debounce;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
